// File: rtl/text_pixel_pipe.sv
// text_pixel_pipe
//   Two-stage text-mode pixel renderer. Stage 0 decodes the character cell
//   from the incoming pixel coordinate and issues the text-buffer read.
//   Stage 1 presents the returned character, plus the row and column within
//   the glyph, to an external glyph LUT. Stage 2 registers the lit bit, with
//   the blinking block cursor overlaid, and the delay-matched timing flags.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   px_x, px_y                pixel coordinate from the timing generator
//   px_active/hsync/vsync     timing flags (syncs active-low)
//   cursor_en/col/row         cursor overlay control
//   tb_addr / tb_data         text-buffer read port (data one cycle later)
//   lut_char/vidx/hidx        glyph LUT lookup
//   lut_lit                   glyph LUT result (combinational)
//   pix_on/active/hsync/vsync rendered pixel and flags, 2 cycles after px_*

module text_pixel_pipe #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int ADDR_W       = 13,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        px_x,
  input  logic [9:0]        px_y,
  input  logic              px_active,
  input  logic              px_hsync,
  input  logic              px_vsync,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [5:0]        cursor_row,
  output logic [ADDR_W-1:0] tb_addr,
  input  logic [7:0]        tb_data,
  output logic [7:0]        lut_char,
  output logic [2:0]        lut_vidx,
  output logic [2:0]        lut_hidx,
  input  logic              lut_lit,
  output logic              pix_on,
  output logic              pix_active,
  output logic              pix_hsync,
  output logic              pix_vsync
);

  localparam int FCW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

  // stage 0 decode
  logic [6:0] col;
  logic [6:0] row;
  logic       in_range;
  logic       cur_hit;

  // stage 1
  logic [2:0] vidx1_q, vidx1_d;
  logic [2:0] hidx1_q, hidx1_d;
  logic       act1_q, act1_d;
  logic       cur1_q, cur1_d;
  logic       hs1_q, hs1_d;
  logic       vs1_q, vs1_d;

  // stage 2
  logic       pix_on_q, pix_on_d;
  logic       pix_active_q, pix_active_d;
  logic       pix_hsync_q, pix_hsync_d;
  logic       pix_vsync_q, pix_vsync_d;

  // blink
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic           vs_prev_q, vs_prev_d;
  logic           frame_evt;

  always_comb begin
    col      = px_x[9:3];
    row      = px_y[9:3];
    in_range = px_active && (int'(col) < COLS) && (int'(row) < ROWS);
    tb_addr  = '0;
    if (in_range) begin
      tb_addr = ADDR_W'(ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col));
    end
    cur_hit = cursor_en && (col == cursor_col) && (row == {1'b0, cursor_row})
              && in_range;
  end

  always_comb begin
    vidx1_d = px_y[2:0];
    hidx1_d = px_x[2:0];
    act1_d  = in_range;
    cur1_d  = cur_hit;
    hs1_d   = px_hsync;
    vs1_d   = px_vsync;
  end

  always_comb begin
    lut_char = tb_data;
    lut_vidx = vidx1_q;
    lut_hidx = hidx1_q;
  end

  // blink_on_q is the pre-toggle value on an edge that also carries a frame
  // event, so the cursor pixel at that edge renders with the old phase.
  always_comb begin
    pix_on_d     = act1_q & (lut_lit ^ (cur1_q & blink_on_q));
    pix_active_d = act1_q;
    pix_hsync_d  = hs1_q;
    pix_vsync_d  = vs1_q;
  end

  always_comb begin
    frame_evt   = vs_prev_q & ~px_vsync;
    vs_prev_d   = px_vsync;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (frame_evt) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vidx1_q      <= '0;
      hidx1_q      <= '0;
      act1_q       <= 1'b0;
      cur1_q       <= 1'b0;
      hs1_q        <= 1'b1;
      vs1_q        <= 1'b1;
      pix_on_q     <= 1'b0;
      pix_active_q <= 1'b0;
      pix_hsync_q  <= 1'b1;
      pix_vsync_q  <= 1'b1;
      frame_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      vs_prev_q    <= 1'b1;
    end else begin
      vidx1_q      <= vidx1_d;
      hidx1_q      <= hidx1_d;
      act1_q       <= act1_d;
      cur1_q       <= cur1_d;
      hs1_q        <= hs1_d;
      vs1_q        <= vs1_d;
      pix_on_q     <= pix_on_d;
      pix_active_q <= pix_active_d;
      pix_hsync_q  <= pix_hsync_d;
      pix_vsync_q  <= pix_vsync_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_on_q   <= blink_on_d;
      vs_prev_q    <= vs_prev_d;
    end
  end

  assign pix_on     = pix_on_q;
  assign pix_active = pix_active_q;
  assign pix_hsync  = pix_hsync_q;
  assign pix_vsync  = pix_vsync_q;

endmodule

// File: tb/tb_text_pixel_pipe.sv
// tb_text_pixel_pipe
//   Bench for text_pixel_pipe with a synchronous text-buffer RAM model, a
//   combinational glyph LUT model and an expected-output queue computed from
//   cell arithmetic and a count of vsync falling edges.

module tb_text_pixel_pipe;

  localparam int BF = 2;

  logic        clk;
  logic        rst;
  logic [9:0]  px_x, px_y;
  logic        px_active, px_hsync, px_vsync;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [12:0] tb_addr;
  logic [7:0]  tb_data;
  logic [7:0]  lut_char;
  logic [2:0]  lut_vidx, lut_hidx;
  logic        lut_lit;
  logic        pix_on, pix_active, pix_hsync, pix_vsync;

  text_pixel_pipe #(.COLS(80), .ROWS(60), .ADDR_W(13), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .px_x(px_x), .px_y(px_y), .px_active(px_active),
    .px_hsync(px_hsync), .px_vsync(px_vsync),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .tb_addr(tb_addr), .tb_data(tb_data),
    .lut_char(lut_char), .lut_vidx(lut_vidx), .lut_hidx(lut_hidx),
    .lut_lit(lut_lit),
    .pix_on(pix_on), .pix_active(pix_active),
    .pix_hsync(pix_hsync), .pix_vsync(pix_vsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];
  always @(posedge clk) tb_data <= mem[tb_addr];

  function automatic logic [7:0] glyph(input logic [7:0] ch, input logic [2:0] v);
    if (ch == 8'h71 && v == 3'd2) return 8'h76;
    return (ch * 8'd29 + {5'd0, v} * 8'd53) ^ 8'h5A;
  endfunction

  logic [7:0] lut_row;
  always_comb begin
    lut_row = glyph(lut_char, lut_vidx);
    lut_lit = lut_row[3'd7 - lut_hidx];
  end

  typedef struct packed {logic on; logic act; logic hs; logic vs;} exp_t;
  exp_t q[$];

  int   n_asrt = 0;
  int   n_fail = 0;
  int   falls;
  bit   prev_vs;
  logic obs_on;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_asrt++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_pix_on", 32'(pix_on), 0);
    chk("rst_pix_active", 32'(pix_active), 0);
    chk("rst_pix_hsync", 32'(pix_hsync), 1);
    chk("rst_pix_vsync", 32'(pix_vsync), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_pix_active", 32'(pix_active), 0);
    chk("rel_pix_vsync", 32'(pix_vsync), 1);
    q.delete();
    q.push_back('{on: 1'b0, act: 1'b0, hs: 1'b1, vs: 1'b1});
    falls   = 0;
    prev_vs = 1'b1;
  endtask

  task automatic cyc(input int x, input int y, input bit act, input bit hs, input bit vs);
    int col, row, addr;
    bit inr, hit, blink, lit;
    logic [7:0] g;
    exp_t e, got;
    px_x = 10'(x); px_y = 10'(y);
    px_active = act; px_hsync = hs; px_vsync = vs;
    if (prev_vs && !vs) falls++;
    prev_vs = vs;
    blink = ((falls / BF) % 2) == 0;
    col  = x / 8;
    row  = y / 8;
    inr  = act && col < 80 && row < 60;
    addr = inr ? row * 80 + col : 0;
    g    = glyph(mem[addr], 3'(y % 8));
    lit  = g[7 - (x % 8)];
    hit  = cursor_en && col == int'(cursor_col) && row == int'(cursor_row) && inr;
    e    = '{on: inr & (lit ^ (hit & blink)), act: inr, hs: hs, vs: vs};
    q.push_back(e);
    #1 chk("tb_addr", 32'(tb_addr), 32'(addr));
    @(posedge clk);
    #1;
    chk("lut_char", 32'(lut_char), 32'(mem[addr]));
    chk("lut_vidx", 32'(lut_vidx), 32'(y % 8));
    chk("lut_hidx", 32'(lut_hidx), 32'(x % 8));
    @(negedge clk);
    got = q.pop_front();
    chk("pix_on", 32'(pix_on), 32'(got.on));
    chk("pix_active", 32'(pix_active), 32'(got.act));
    chk("pix_hsync", 32'(pix_hsync), 32'(got.hs));
    chk("pix_vsync", 32'(pix_vsync), 32'(got.vs));
    obs_on = pix_on;
  endtask

  // pixels (0..7, 2) of cell 0; bit 7 holds x=0
  task automatic sweep(output logic [7:0] obs);
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(i, 2, 1'b1, 1'b1, 1'b1);
      if (i > 0) obs[8 - i] = obs_on;
    end
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    obs[0] = obs_on;
  endtask

  task automatic two_frames();
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 1'b0, 1'b1, 1'b0);
      cyc(0, 0, 1'b0, 1'b1, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] a_row;
    rst = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0]  = 8'h71;
    mem[82] = 8'h41;
    cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
    px_x = 10'd17; px_y = 10'd10; px_active = 1'b1; px_hsync = 1'b1; px_vsync = 1'b1;
    do_reset();

    cyc(17, 10, 1'b1, 1'b1, 1'b1);
    chk("addr_lut_char", 32'(lut_char), 32'h41);
    chk("addr_lut_vidx", 32'(lut_vidx), 2);
    chk("addr_lut_hidx", 32'(lut_hidx), 1);
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    a_row = glyph(8'h41, 3'd2);
    chk("addr_pix_on", 32'(obs_on), 32'(a_row[6]));

    sweep(pat);
    chk("sweep_plain", 32'(pat), 32'h76);

    cursor_en = 1'b1;
    sweep(pat);
    chk("sweep_cursor_on", 32'(pat), 32'h89);
    two_frames();
    sweep(pat);
    chk("sweep_cursor_off", 32'(pat), 32'h76);
    two_frames();
    sweep(pat);
    chk("sweep_cursor_back", 32'(pat), 32'h89);

    cursor_en = 1'b0;
    cyc(0, 2, 1'b0, 1'b0, 1'b1);
    cyc(1, 2, 1'b0, 1'b1, 1'b0);
    chk("blank_pix_on", 32'(obs_on), 0);
    chk("blank_hsync", 32'(pix_hsync), 0);
    cyc(640, 16, 1'b1, 1'b1, 1'b1);
    chk("range_tb_addr", 32'(tb_addr), 0);
    chk("blank_vsync", 32'(pix_vsync), 0);
    cyc(0, 0, 1'b0, 1'b1, 1'b1);
    chk("range_pix_on", 32'(obs_on), 0);
    chk("range_pix_active", 32'(pix_active), 0);

    for (int i = 0; i < 4; i++) cyc(i, 2, 1'b1, 1'b1, 1'b1);
    do_reset();
    sweep(pat);
    chk("sweep_after_rst", 32'(pat), 32'h76);

    for (int n = 0; n < 400; n++) begin
      int x, y;
      x = $urandom_range(0, 799);
      y = $urandom_range(0, 524);
      if ($urandom_range(0, 15) == 0) begin
        cursor_en  = 1'($urandom);
        cursor_col = 7'(x / 8);
        cursor_row = 6'(y / 8);
      end
      if ($urandom_range(0, 2) == 0) begin
        x = int'(cursor_col) * 8 + $urandom_range(0, 7);
        y = int'(cursor_row) * 8 + $urandom_range(0, 7);
      end
      cyc(x, y, $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
